bcd_display_scheduler: RTL
==========================

Name: bcd_display_scheduler

Overview:
- Time-multiplexes up to N_REQ requesters (CPU register taps such as PC, ACC and IR) onto one shared combinational binary-to-BCD converter.
- Each requester supplies a 7-bit value. The converter's 4-bit digit outputs are latched into registered display digits, which feed the 7-segment decoders.
- Arbitration is round-robin. Each grant has a fixed dwell time, so every active channel is shown in turn.

Parameters:
- N_REQ, 4, number of requesters (2..8); SEL_W = $clog2(N_REQ).
- DWELL, 4, cycles a captured channel stays on the display (>=1; boards use e.g. 25_000_000).
- CNT_W, 32, dwell counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-channel display request, level-sensitive.
- values  in  7*N_REQ  channel i value at [7*i+6:7*i].
- grant  out  N_REQ  one-hot; channel currently converted/displayed.
- bcd_binary  out  7  registered drive to converter input.
- bcd_hundreds  in  4  converter hundreds digit.
- bcd_tens  in  4  converter tens digit.
- bcd_ones  in  4  converter ones digit.
- disp_hundreds  out  4  registered display digit.
- disp_tens  out  4  registered display digit.
- disp_ones  out  4  registered display digit.
- disp_channel  out  SEL_W  index of the channel on display.
- disp_valid  out  1  display holds a granted channel's value.

Behaviour:
- Converter codes: 126 (7'b1111110) yields blank digits 4'b1011. 127 (7'b1111111) yields dash digits 4'b1010. Values 0..125 yield decimal digits.
- Reset (reset==0 at an edge) sets:
  - state IDLE, grant 0, bcd_binary 7'b1111110;
  - disp_* 4'b1011, disp_channel 0, disp_valid 0;
  - rr pointer N_REQ-1, so channel 0 wins first;
  - dwell count 0.
- Reset mid-operation aborts any slot on the same edge.
- FSM states are IDLE, CAPTURE and DWELL.
- IDLE with no req bits set:
  - bcd_binary <= 126; disp_* <= 4'b1011; disp_valid <= 0; grant <= 0;
  - stay in IDLE.
- IDLE with any req bit set:
  - sel <= first set req index searching ptr+1, ptr+2, ... with wrap modulo N_REQ;
  - grant <= onehot(sel);
  - bcd_binary <= values[sel] (snapshot; later changes ignored for this slot);
  - ptr <= sel; go to CAPTURE.
- CAPTURE (converter has settled for one full cycle):
  - disp_hundreds/tens/ones <= bcd_hundreds/tens/ones; disp_channel <= sel; disp_valid <= 1;
  - count <= DWELL-1; go to DWELL.
- DWELL:
  - if req[sel]==0: go to IDLE next edge; grant <= 0; display retains its digits.
  - else if count==0: go to IDLE; grant <= 0.
  - else count <= count-1.
- Latency: req sampled at edge k gives grant and bcd_binary at k+1 and disp_* at k+2. Slot length is DWELL+2 cycles including the IDLE arbitration cycle.
- grant is never multi-hot and is 0 only in IDLE, or after an abort/expiry edge.
- A single active requester is re-granted back-to-back, and the display refreshes with its current value each slot.
- New req bits raised during DWELL wait for the next IDLE arbitration. No preemption.
- disp_valid stays 1 across slots. It clears only in IDLE with no requests, or on reset.

Optional Feature:
- Macro PRIORITY_CH0_EN.
- Defined: in IDLE, req[0]==1 always wins regardless of ptr, and ptr is not updated by a channel-0 win. Round-robin applies among channels 1..N_REQ-1 only when req[0]==0.
- Undefined: pure round-robin as above.

Test Plan:
- Reset for 3 cycles, release, req=0. Required: disp_* =4'b1011, disp_valid=0, bcd_binary=126 and grant=0 for 10 cycles.
- req=4'b0001, ch0=7'd123, stub converter. Required: grant=0001 and bcd_binary=123 at k+1; disp=1,2,3, disp_channel=0, disp_valid=1 at k+2; slot repeats every 6 cycles (DWELL=4).
- req=4'b1011, values 5/17/—/99. Required: display order ch0, ch1, ch3, ch0, each held 4 cycles; grant is always one-hot.
- ch1=7'd127 granted. Required: disp_* =4'b1010. Change ch1 to 42 mid-DWELL: display stays dash until the next slot.
- Drop req[sel] in the 2nd DWELL cycle. Required: grant=0 next edge, digits retained, next arbitration the following cycle. Assert reset mid-DWELL: all outputs at reset values next edge.
- With PRIORITY_CH0_EN and req=4'b0111 steady: every slot is ch0. Drop req[0]: ch1 then ch2 alternate.

Source files
------------

// File: rtl/bcd_display_scheduler_if.sv
// ---------------------------------------------------------------------------
// bcd_display_scheduler_if
//
// Purpose:
//   Bundles everything that passes between the display scheduler and the
//   rest of the board: the requester taps, the shared binary-to-BCD
//   converter and the registered display digits.
//
// Signals:
//   req           per-channel display request, level-sensitive
//   values        channel i value at [7*i+6:7*i]
//   grant         one-hot, channel currently converted/displayed
//   bcd_binary    registered drive into the shared converter
//   bcd_hundreds  converter hundreds digit (combinational return)
//   bcd_tens      converter tens digit
//   bcd_ones      converter ones digit
//   disp_*        registered display digits feeding the 7-segment decoders
//   disp_channel  index of the channel on display
//   disp_valid    display holds a granted channel's value
//
// Modports:
//   slave   the scheduler itself
//   master  the surroundings (requesters + converter)
// ---------------------------------------------------------------------------
interface bcd_display_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int SEL_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] values;
  logic [N_REQ-1:0]   grant;
  logic [6:0]         bcd_binary;
  logic [3:0]         bcd_hundreds;
  logic [3:0]         bcd_tens;
  logic [3:0]         bcd_ones;
  logic [3:0]         disp_hundreds;
  logic [3:0]         disp_tens;
  logic [3:0]         disp_ones;
  logic [SEL_W-1:0]   disp_channel;
  logic               disp_valid;

  modport slave (
    input  req, values, bcd_hundreds, bcd_tens, bcd_ones,
    output grant, bcd_binary, disp_hundreds, disp_tens, disp_ones,
           disp_channel, disp_valid
  );

  modport master (
    output req, values, bcd_hundreds, bcd_tens, bcd_ones,
    input  grant, bcd_binary, disp_hundreds, disp_tens, disp_ones,
           disp_channel, disp_valid
  );
endinterface

// File: rtl/bcd_display_scheduler.sv
// ---------------------------------------------------------------------------
// bcd_display_scheduler
//
// Purpose:
//   Time-multiplexes up to N_REQ requesters (CPU register taps such as PC,
//   ACC, IR) onto one shared combinational binary-to-BCD converter.  A
//   round-robin arbiter picks a channel, drives its 7-bit value into the
//   converter, latches the converter digits one cycle later and holds them
//   on the display for DWELL cycles.
//
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-low reset
//   bus    bcd_display_scheduler_if.slave (requests, values, grant,
//          converter drive/return, display digits, channel, valid)
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   DWELL  cycles a captured channel stays on the display (>=1)
//   CNT_W  dwell counter width
//
// Optional build macro:
//   PRIORITY_CH0_EN  when defined, req[0] always wins arbitration and does
//                    not move the round-robin pointer; the remaining
//                    channels share round-robin among themselves.
// ---------------------------------------------------------------------------
module bcd_display_scheduler #(
  parameter int N_REQ = 4,
  parameter int DWELL = 4,
  parameter int CNT_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  bcd_display_scheduler_if.slave   bus
);

  localparam int SEL_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] GRANT_LSB = N_REQ'(1);
  localparam logic [6:0] CODE_BLANK = 7'd126;
  localparam logic [3:0] DIGIT_BLANK = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DWELL
  } state_t;

  state_t           r_state,        w_state;
  logic [N_REQ-1:0] r_grant,        w_grant;
  logic [6:0]       r_bcdBinary,    w_bcdBinary;
  logic [3:0]       r_dispHundreds, w_dispHundreds;
  logic [3:0]       r_dispTens,     w_dispTens;
  logic [3:0]       r_dispOnes,     w_dispOnes;
  logic [SEL_W-1:0] r_dispChannel,  w_dispChannel;
  logic             r_dispValid,    w_dispValid;
  logic [SEL_W-1:0] r_ptr,          w_ptr;
  logic [SEL_W-1:0] r_sel,          w_sel;
  logic [CNT_W-1:0] r_count,        w_count;

  logic             w_found;
  logic [SEL_W-1:0] w_pick;
  logic             w_updPtr;

  // Arbiter: look for the first requesting channel starting just after the
  // last winner and wrapping around.  The loop runs from the farthest
  // candidate to the nearest so the nearest one overwrites the others and
  // ends up as the pick.  With channel-0 priority built in, a raised req[0]
  // overrides whatever the round-robin found and leaves the pointer alone,
  // so the other channels keep their place in the rotation.
  always_comb begin
    w_found  = 1'b0;
    w_pick   = '0;
    w_updPtr = 1'b1;
    for (int i = N_REQ; i >= 1; i--) begin
      if (bus.req[(int'(r_ptr) + i) % N_REQ]) begin
        w_found = 1'b1;
        w_pick  = SEL_W'((int'(r_ptr) + i) % N_REQ);
      end
    end
`ifdef PRIORITY_CH0_EN
    if (bus.req[0]) begin
      w_found  = 1'b1;
      w_pick   = '0;
      w_updPtr = 1'b0;
    end
`else
    w_updPtr = 1'b1;
`endif
  end

  // Next-state and next-output logic.  IDLE arbitrates and snapshots the
  // winner's value into the converter drive; CAPTURE gives the converter a
  // full cycle to settle before its digits are latched; DWELL holds the
  // display, returning to IDLE early if the shown channel drops its request.
  // The display digits are deliberately left alone on abort/expiry so the
  // last value stays visible until something new is captured or everyone
  // goes quiet.
  always_comb begin
    w_state        = r_state;
    w_grant        = r_grant;
    w_bcdBinary    = r_bcdBinary;
    w_dispHundreds = r_dispHundreds;
    w_dispTens     = r_dispTens;
    w_dispOnes     = r_dispOnes;
    w_dispChannel  = r_dispChannel;
    w_dispValid    = r_dispValid;
    w_ptr          = r_ptr;
    w_sel          = r_sel;
    w_count        = r_count;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_sel       = w_pick;
          w_grant     = GRANT_LSB << w_pick;
          w_bcdBinary = bus.values[int'(w_pick) * 7 +: 7];
          if (w_updPtr) begin
            w_ptr = w_pick;
          end
          w_state = S_CAPTURE;
        end else begin
          w_bcdBinary    = CODE_BLANK;
          w_dispHundreds = DIGIT_BLANK;
          w_dispTens     = DIGIT_BLANK;
          w_dispOnes     = DIGIT_BLANK;
          w_dispValid    = 1'b0;
          w_grant        = '0;
        end
      end

      S_CAPTURE: begin
        w_dispHundreds = bus.bcd_hundreds;
        w_dispTens     = bus.bcd_tens;
        w_dispOnes     = bus.bcd_ones;
        w_dispChannel  = r_sel;
        w_dispValid    = 1'b1;
        w_count        = CNT_W'(DWELL - 1);
        w_state        = S_DWELL;
      end

      S_DWELL: begin
        if (!bus.req[r_sel] || (r_count == '0)) begin
          w_state = S_IDLE;
          w_grant = '0;
        end else begin
          w_count = r_count - CNT_W'(1);
        end
      end

      default: begin
        w_state = S_IDLE;
        w_grant = '0;
      end
    endcase
  end

  // State register.  Reset is synchronous and active-low; it wins over any
  // slot in progress on the same edge.  The pointer starts at the last
  // channel so channel 0 is the first one served.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_grant        <= '0;
      r_bcdBinary    <= CODE_BLANK;
      r_dispHundreds <= DIGIT_BLANK;
      r_dispTens     <= DIGIT_BLANK;
      r_dispOnes     <= DIGIT_BLANK;
      r_dispChannel  <= '0;
      r_dispValid    <= 1'b0;
      r_ptr          <= SEL_W'(N_REQ - 1);
      r_sel          <= '0;
      r_count        <= '0;
    end else begin
      r_state        <= w_state;
      r_grant        <= w_grant;
      r_bcdBinary    <= w_bcdBinary;
      r_dispHundreds <= w_dispHundreds;
      r_dispTens     <= w_dispTens;
      r_dispOnes     <= w_dispOnes;
      r_dispChannel  <= w_dispChannel;
      r_dispValid    <= w_dispValid;
      r_ptr          <= w_ptr;
      r_sel          <= w_sel;
      r_count        <= w_count;
    end
  end

  assign bus.grant         = r_grant;
  assign bus.bcd_binary    = r_bcdBinary;
  assign bus.disp_hundreds = r_dispHundreds;
  assign bus.disp_tens     = r_dispTens;
  assign bus.disp_ones     = r_dispOnes;
  assign bus.disp_channel  = r_dispChannel;
  assign bus.disp_valid    = r_dispValid;

endmodule
